// File: rtl/bg_pixel_fifo_if.sv
// Pixel type shared by the PPU pipeline, and the fetcher/mixer-facing bundle
// of the background pixel FIFO.
package ppu_pkg;
  typedef struct packed {
    logic       bg_prio;
    logic [2:0] palette;
    logic [1:0] color;
  } ppu_pixel_t;
endpackage

interface bg_pixel_fifo_if #(parameter int DEPTH = 16);
  import ppu_pkg::*;

  logic                   dot_en;
  logic                   line_start;
  logic                   flush;
  logic [2:0]             scx_fine;
  logic                   pop_stall;
  logic                   push_en;
  ppu_pixel_t             push_px;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   out_valid;
  ppu_pixel_t             out_px;
  logic [7:0]             out_x;
  logic                   line_done;
  logic                   overflow;

  modport master (
    output dot_en, line_start, flush, scx_fine, pop_stall, push_en, push_px,
    input  full, empty, count, out_valid, out_px, out_x, line_done, overflow
  );

  modport slave (
    input  dot_en, line_start, flush, scx_fine, pop_stall, push_en, push_px,
    output full, empty, count, out_valid, out_px, out_x, line_done, overflow
  );
endinterface

// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO: buffers fetched pixels, drops the first SCX[2:0]
// pixels of a scanline, then emits one pixel per dot with its screen X.
module bg_pixel_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int X_MAX = 160
) (
  input  logic            clk,
  input  logic            reset,
  bg_pixel_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DISCARD, S_OUTPUT, S_DONE} state_t;

  state_t          r_state;
  state_t          w_stateNext;
  ppu_pixel_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;
  logic            r_full;
  logic            r_empty;
  logic [2:0]      r_discardCnt;
  logic [7:0]      r_xCnt;
  logic            r_outValid;
  ppu_pixel_t      r_outPx;
  logic [7:0]      r_outX;
  logic            r_lineDone;
  logic            r_overflow;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_countNext;

  // line_start and flush both reset occupancy, so they suppress push and pop.
  always_comb begin
    w_stateNext = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_countNext = r_count;
    if (!bus.line_start && !bus.flush) begin
      w_push      = bus.push_en && !r_full;
      w_pop       = bus.dot_en && !bus.pop_stall && !r_empty &&
                    (r_state == S_DISCARD || r_state == S_OUTPUT);
      w_countNext = r_count + CW'(w_push) - CW'(w_pop);
    end
    if (bus.line_start) begin
      w_stateNext = (bus.scx_fine != 3'd0) ? S_DISCARD : S_OUTPUT;
    end else if (w_pop) begin
      case (r_state)
        S_DISCARD: if (r_discardCnt == 3'd1) w_stateNext = S_OUTPUT;
        S_OUTPUT:  if (r_xCnt == 8'(X_MAX - 1)) w_stateNext = S_DONE;
        default:   w_stateNext = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_stateNext;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= bus.push_px;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_discardCnt <= 3'd0;
      r_xCnt       <= 8'd0;
      r_outValid   <= 1'b0;
      r_outPx      <= '0;
      r_outX       <= 8'd0;
      r_lineDone   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      if (bus.line_start) begin
        r_wrPtr      <= '0;
        r_rdPtr      <= '0;
        r_count      <= '0;
        r_full       <= 1'b0;
        r_empty      <= 1'b1;
        r_discardCnt <= bus.scx_fine;
        r_xCnt       <= 8'd0;
        r_outX       <= 8'd0;
        r_lineDone   <= 1'b0;
        r_overflow   <= 1'b0;
      end else if (bus.flush) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
        r_count <= '0;
        r_full  <= 1'b0;
        r_empty <= 1'b1;
      end else begin
        if (bus.push_en && r_full) r_overflow <= 1'b1;
        if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
        r_count <= w_countNext;
        r_full  <= (w_countNext == CW'(DEPTH));
        r_empty <= (w_countNext == '0);
        if (w_pop) begin
          r_rdPtr <= r_rdPtr + 1'b1;
          if (r_state == S_DISCARD) begin
            r_discardCnt <= r_discardCnt - 3'd1;
          end else begin
            r_outValid <= 1'b1;
            r_outPx    <= r_mem[r_rdPtr];
            r_outX     <= r_xCnt;
            r_xCnt     <= r_xCnt + 8'd1;
            if (r_xCnt == 8'(X_MAX - 1)) r_lineDone <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.full      = r_full;
  assign bus.empty     = r_empty;
  assign bus.count     = r_count;
  assign bus.out_valid = r_outValid;
  assign bus.out_px    = r_outPx;
  assign bus.out_x     = r_outX;
  assign bus.line_done = r_lineDone;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_bg_pixel_fifo.sv
// Directed bench for bg_pixel_fifo: fine-scroll discard, full-line emission,
// overflow, stall, flush and mid-line reset with hand-computed expectations.
module tb_bg_pixel_fifo;
  import ppu_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   qX[$];
  int   qC[$];
  int   qDone[$];
  int   bad;
  int   stallValids;

  bg_pixel_fifo_if #(.DEPTH(16)) bus ();

  bg_pixel_fifo #(.DEPTH(16), .X_MAX(160)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One dot: drive the push, clock it, then sample just after the edge.
  task automatic applyStimulus(input logic push, input logic [1:0] color);
    bus.push_en       = push;
    bus.push_px       = '0;
    bus.push_px.color = color;
    @(posedge clk);
    #1;
    if (bus.out_valid) begin
      qX.push_back(int'(bus.out_x));
      qC.push_back(int'(bus.out_px.color));
      qDone.push_back(int'(bus.line_done));
    end
  endtask

  task automatic startLine(input logic [2:0] scx);
    bus.line_start = 1'b1;
    bus.scx_fine   = scx;
    applyStimulus(1'b0, 2'd0);
    bus.line_start = 1'b0;
    qX.delete();
    qC.delete();
    qDone.delete();
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    reset          = 1'b1;
    bus.dot_en     = 1'b0;
    bus.line_start = 1'b0;
    bus.flush      = 1'b0;
    bus.scx_fine   = 3'd0;
    bus.pop_stall  = 1'b0;
    bus.push_en    = 1'b0;
    bus.push_px    = '0;
    #3;
    checkOutput("rst_full", int'(bus.full), 0);
    checkOutput("rst_empty", int'(bus.empty), 1);
    checkOutput("rst_count", int'(bus.count), 0);
    checkOutput("rst_valid", int'(bus.out_valid), 0);
    checkOutput("rst_outx", int'(bus.out_x), 0);
    checkOutput("rst_done", int'(bus.line_done), 0);
    checkOutput("rst_ovf", int'(bus.overflow), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fine scroll of 3: colors 0,1,2 are dropped, output starts at color 3.
    bus.dot_en = 1'b1;
    startLine(3'd3);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 2'(i % 4));
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'd0);
    checkOutput("scx3_nout", qX.size(), 5);
    checkOutput("scx3_c0", (qC.size() > 0) ? qC[0] : -1, 3);
    checkOutput("scx3_x0", (qX.size() > 0) ? qX[0] : -1, 0);
    checkOutput("scx3_c1", (qC.size() > 1) ? qC[1] : -1, 0);
    checkOutput("scx3_x1", (qX.size() > 1) ? qX[1] : -1, 1);

    // Full line with no scroll: 170 pushes, exactly 160 emitted.
    startLine(3'd0);
    for (int i = 0; i < 170; i++) applyStimulus(1'b1, 2'(i % 4));
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'd0);
    checkOutput("line_nout", qX.size(), 160);
    bad = 0;
    foreach (qX[k]) if (qX[k] != k || qC[k] != k % 4) bad++;
    checkOutput("line_seq", bad, 0);
    checkOutput("line_done158", (qDone.size() > 158) ? qDone[158] : -1, 0);
    checkOutput("line_done", int'(bus.line_done), 1);
    checkOutput("line_left", int'(bus.count), 10);
    checkOutput("line_ovf", int'(bus.overflow), 0);

    // Fill without dot_en, then overflow, then line_start clears it.
    bus.dot_en = 1'b0;
    startLine(3'd0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'd1);
    checkOutput("fill_full", int'(bus.full), 1);
    checkOutput("fill_count", int'(bus.count), 16);
    checkOutput("fill_ovf0", int'(bus.overflow), 0);
    applyStimulus(1'b1, 2'd2);
    checkOutput("fill_ovf1", int'(bus.overflow), 1);
    checkOutput("fill_count17", int'(bus.count), 16);
    startLine(3'd0);
    checkOutput("fill_clr_ovf", int'(bus.overflow), 0);
    checkOutput("fill_clr_cnt", int'(bus.count), 0);
    checkOutput("fill_clr_empty", int'(bus.empty), 1);

    // Six stalled dots in the middle of the stream.
    bus.dot_en  = 1'b1;
    stallValids = 0;
    startLine(3'd0);
    for (int i = 0; i < 40; i++) begin
      bus.pop_stall = (i >= 10 && i < 16);
      applyStimulus(1'b1, 2'(i % 4));
      if (bus.pop_stall && bus.out_valid) stallValids++;
    end
    bus.pop_stall = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 2'd0);
    checkOutput("stall_valid", stallValids, 0);
    checkOutput("stall_nout", qX.size(), 40);
    bad = 0;
    foreach (qX[k]) if (qX[k] != k || qC[k] != k % 4) bad++;
    checkOutput("stall_seq", bad, 0);

    // Flush at count 5 with a simultaneous push.
    startLine(3'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd0);
    checkOutput("fl_outx_pre", int'(bus.out_x), 2);
    bus.dot_en = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd3);
    checkOutput("fl_count_pre", int'(bus.count), 5);
    bus.flush = 1'b1;
    applyStimulus(1'b1, 2'd3);
    bus.flush = 1'b0;
    checkOutput("fl_count", int'(bus.count), 0);
    checkOutput("fl_empty", int'(bus.empty), 1);
    checkOutput("fl_outx", int'(bus.out_x), 2);
    bus.dot_en = 1'b1;
    qX.delete();
    qC.delete();
    applyStimulus(1'b1, 2'd1);
    applyStimulus(1'b0, 2'd0);
    applyStimulus(1'b0, 2'd0);
    checkOutput("fl_nout", qX.size(), 1);
    checkOutput("fl_next_x", (qX.size() > 0) ? qX[0] : -1, 3);
    checkOutput("fl_next_c", (qC.size() > 0) ? qC[0] : -1, 1);

    // Reset in the middle of a line with out_x=37 and count=9.
    startLine(3'd0);
    for (int i = 0; i < 38; i++) applyStimulus(1'b1, 2'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'd0);
    checkOutput("mr_outx_pre", int'(bus.out_x), 37);
    bus.dot_en = 1'b0;
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 2'd0);
    checkOutput("mr_count_pre", int'(bus.count), 9);
    bus.push_en = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mr_outx", int'(bus.out_x), 0);
    checkOutput("mr_count", int'(bus.count), 0);
    checkOutput("mr_empty", int'(bus.empty), 1);
    checkOutput("mr_full", int'(bus.full), 0);
    checkOutput("mr_valid", int'(bus.out_valid), 0);
    applyStimulus(1'b1, 2'd0);
    applyStimulus(1'b1, 2'd0);
    checkOutput("mr_push_ign", int'(bus.count), 0);
    reset = 1'b0;
    bus.dot_en = 1'b1;
    qX.delete();
    applyStimulus(1'b1, 2'd0);
    applyStimulus(1'b1, 2'd0);
    applyStimulus(1'b0, 2'd0);
    applyStimulus(1'b0, 2'd0);
    checkOutput("idle_count", int'(bus.count), 2);
    checkOutput("idle_nout", qX.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
